multi_alarm_ctrl: RTL and testbench

Parametrised multi-channel alarm unit; next generation of the single alarm inside the clock mode FSM. Holds NUM_ALARMS independently programmable alarms, each with its own arm/ring/snooze state, compared against the running clock time. Adds snooze with a limit, ring timeout and priority arbitration of one shared buzzer. Sits beside the clock/date counters and is driven by the mode FSM's button lines.

---
 rtl/multi_alarm_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm unit: per-channel arm/ring/snooze FSMs sharing one buzzer.
// Optional ALARM_DAYMASK_EN adds a per-channel weekday mask to the match condition.
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SECS  = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [5:0]            hr,
    input  logic [5:0]            min,
    input  logic [5:0]            sec,
    input  logic [IDX_W-1:0]      sel,
    input  logic                  add_hour,
    input  logic                  add_minute,
    input  logic                  set_alarm_btn,
    input  logic                  clr_alarm_btn,
    input  logic                  snooze_btn,
    input  logic                  dismiss_btn,
`ifdef ALARM_DAYMASK_EN
    input  logic [2:0]            weekday,
    input  logic                  day_toggle,
    output logic [6:0]            sel_daymask,
`endif
    output logic                  alarm_buzzer,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic [5:0]            sel_hr,
    output logic [5:0]            sel_min
);

    localparam int CD_LOAD = SNOOZE_MIN * 60;
    localparam int CD_W    = $clog2(CD_LOAD + 1);
    localparam int SC_W    = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} state_t;

    typedef struct packed {
        state_t          st;
        logic [5:0]      hour;
        logic [5:0]      minute;
        logic [7:0]      ring_cnt;
        logic [SC_W-1:0] snz_cnt;
        logic [CD_W-1:0] cd;
`ifdef ALARM_DAYMASK_EN
        logic [6:0]      mask;
`endif
    } chan_t;

    chan_t cur [NUM_ALARMS];
    chan_t nxt [NUM_ALARMS];

    function automatic chan_t rearm(input chan_t c);
        chan_t r;
        r          = c;
        r.st       = ARMED;
        r.ring_cnt = '0;
        r.snz_cnt  = '0;
        r.cd       = '0;
        return r;
    endfunction

    // Snooze while budget remains; once exhausted the snooze acts as a dismiss.
    function automatic chan_t snooze_or_dismiss(input chan_t c);
        chan_t r;
        if (int'(c.snz_cnt) < MAX_SNOOZE) begin
            r          = c;
            r.st       = SNOOZED;
            r.snz_cnt  = c.snz_cnt + SC_W'(1);
            r.cd       = CD_W'(CD_LOAD);
            r.ring_cnt = '0;
        end else begin
            r = rearm(c);
        end
        return r;
    endfunction

    logic sel_ok, hit, edit, match, lower_ring, is_owner;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sel_ok     = int'(sel) < NUM_ALARMS;
        hit        = 1'b0;
        edit       = 1'b0;
        match      = 1'b0;
        is_owner   = 1'b0;
        lower_ring = 1'b0;
        for (int ch = 0; ch < NUM_ALARMS; ch++) begin
            nxt[ch]    = cur[ch];
            hit        = sel_ok && (int'(sel) == ch);
            edit       = hit && (add_hour || add_minute);
            is_owner   = (cur[ch].st == RINGING) && !lower_ring;
            lower_ring = lower_ring || (cur[ch].st == RINGING);
            match      = sec_tick && (hr == cur[ch].hour) && (min == cur[ch].minute)
                         && (sec == 6'd0);
`ifdef ALARM_DAYMASK_EN
            match      = match && (weekday < 3'd7) && cur[ch].mask[weekday];
            if (hit && day_toggle && (weekday < 3'd7))
                nxt[ch].mask[weekday] = ~cur[ch].mask[weekday];
`endif
            if (hit && add_hour)
                nxt[ch].hour = (cur[ch].hour >= 6'd23) ? 6'd0 : cur[ch].hour + 6'd1;
            if (hit && add_minute)
                nxt[ch].minute = (cur[ch].minute >= 6'd59) ? 6'd0 : cur[ch].minute + 6'd1;

            if ((hit && clr_alarm_btn) || edit) begin
                nxt[ch].st       = (edit && !clr_alarm_btn && set_alarm_btn) ? ARMED : DISARMED;
                nxt[ch].ring_cnt = '0;
                nxt[ch].snz_cnt  = '0;
                nxt[ch].cd       = '0;
            end else begin
                case (cur[ch].st)
                    DISARMED: if (hit && set_alarm_btn) nxt[ch].st = ARMED;
                    ARMED: if (match) begin
                        nxt[ch].st       = RINGING;
                        nxt[ch].ring_cnt = '0;
                        nxt[ch].snz_cnt  = '0;
                    end
                    RINGING: begin
                        if (is_owner && dismiss_btn)
                            nxt[ch] = rearm(cur[ch]);
                        else if (is_owner && snooze_btn)
                            nxt[ch] = snooze_or_dismiss(cur[ch]);
                        else if (sec_tick) begin
                            if (({1'b0, cur[ch].ring_cnt} + 9'd1) >= 9'(RING_SECS))
                                nxt[ch] = snooze_or_dismiss(cur[ch]);
                            else
                                nxt[ch].ring_cnt = cur[ch].ring_cnt + 8'd1;
                        end
                    end
                    SNOOZED: if (sec_tick) begin
                        if (cur[ch].cd <= CD_W'(1)) begin
                            nxt[ch].st       = RINGING;
                            nxt[ch].ring_cnt = '0;
                            nxt[ch].cd       = '0;
                        end else begin
                            nxt[ch].cd = cur[ch].cd - CD_W'(1);
                        end
                    end
                    default: nxt[ch].st = DISARMED;
                endcase
            end
        end
    end

    // NOTE: the channel array holds live FSM state and counters, so it is reset, not left uninitialised.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_ALARMS; ch++) begin
            if (!reset) begin
                // NOTE: sequential state uses non-blocking assignments only.
                cur[ch] <= '0;
`ifdef ALARM_DAYMASK_EN
                cur[ch].mask <= 7'h7F;
`endif
            end else begin
                cur[ch] <= nxt[ch];
            end
        end
    end

    // Status decodes straight from the state registers, so they follow a transition by one edge.
    always_comb begin
        alarm_buzzer = 1'b0;
        ring_idx     = '0;
        armed        = '0;
        ringing      = '0;
        snoozed      = '0;
        sel_hr       = '0;
        sel_min      = '0;
`ifdef ALARM_DAYMASK_EN
        sel_daymask  = '0;
`endif
        for (int ch = NUM_ALARMS - 1; ch >= 0; ch--) begin
            armed[ch]   = cur[ch].st != DISARMED;
            ringing[ch] = cur[ch].st == RINGING;
            snoozed[ch] = cur[ch].st == SNOOZED;
            if (cur[ch].st == RINGING) begin
                alarm_buzzer = 1'b1;
                ring_idx     = IDX_W'(ch);
            end
            if (sel_ok && (int'(sel) == ch)) begin
                sel_hr  = cur[ch].hour;
                sel_min = cur[ch].minute;
`ifdef ALARM_DAYMASK_EN
                sel_daymask = cur[ch].mask;
`endif
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared against a behavioural model.
module tb_multi_alarm_ctrl;

    localparam int N          = 4;
    localparam int SNOOZE_LEN = 5 * 60;
    localparam int RING_LEN   = 60;
    localparam int MAX_SNZ    = 3;
    localparam int S_OFF = 0, S_ARM = 1, S_RING = 2, S_SNZ = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sec_tick = 1'b0;
    logic [5:0] hr = '0, min = '0, sec = '0;
    logic [1:0] sel = '0;
    logic       add_hour = 0, add_minute = 0, set_alarm_btn = 0, clr_alarm_btn = 0;
    logic       snooze_btn = 0, dismiss_btn = 0;
    logic       alarm_buzzer;
    logic [1:0] ring_idx;
    logic [3:0] armed, ringing, snoozed;
    logic [5:0] sel_hr, sel_min;

    int total = 0;
    int bad   = 0;

    multi_alarm_ctrl dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .hr(hr), .min(min), .sec(sec), .sel(sel),
        .add_hour(add_hour), .add_minute(add_minute),
        .set_alarm_btn(set_alarm_btn), .clr_alarm_btn(clr_alarm_btn),
        .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
        .alarm_buzzer(alarm_buzzer), .ring_idx(ring_idx),
        .armed(armed), .ringing(ringing), .snoozed(snoozed),
        .sel_hr(sel_hr), .sel_min(sel_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per channel, stepped once per rising edge.
    int  m_st [N], m_hr [N], m_mn [N], m_rc [N], m_sc [N], m_cd [N];
    bit  m_valid = 0;

    task automatic m_clear(input int ch, input int st);
        m_st[ch] = st; m_rc[ch] = 0; m_sc[ch] = 0; m_cd[ch] = 0;
    endtask

    task automatic m_snooze(input int ch);
        if (m_sc[ch] < MAX_SNZ) begin
            m_st[ch] = S_SNZ; m_sc[ch]++; m_cd[ch] = SNOOZE_LEN; m_rc[ch] = 0;
        end else begin
            m_clear(ch, S_ARM);
        end
    endtask

    task automatic model_step();
        int  owner;
        bit  pick, ed;
        if (!reset) begin
            for (int ch = 0; ch < N; ch++) begin
                m_clear(ch, S_OFF); m_hr[ch] = 0; m_mn[ch] = 0;
            end
            m_valid = 1;
            return;
        end
        owner = -1;
        for (int ch = 0; ch < N; ch++)
            if (owner < 0 && m_st[ch] == S_RING) owner = ch;
        for (int ch = 0; ch < N; ch++) begin
            pick = (int'(sel) == ch);
            ed   = pick && (add_hour || add_minute);
            if (pick && add_hour)   m_hr[ch] = (m_hr[ch] + 1) % 24;
            if (pick && add_minute) m_mn[ch] = (m_mn[ch] + 1) % 60;
            if (pick && clr_alarm_btn)      m_clear(ch, S_OFF);
            else if (ed)                    m_clear(ch, set_alarm_btn ? S_ARM : S_OFF);
            else if (m_st[ch] == S_OFF) begin
                if (pick && set_alarm_btn) m_st[ch] = S_ARM;
            end else if (m_st[ch] == S_ARM) begin
                if (sec_tick && int'(hr) == m_hr[ch] && int'(min) == m_mn[ch] && sec == 0) begin
                    m_st[ch] = S_RING; m_rc[ch] = 0; m_sc[ch] = 0;
                end
            end else if (m_st[ch] == S_RING) begin
                if (ch == owner && dismiss_btn)     m_clear(ch, S_ARM);
                else if (ch == owner && snooze_btn) m_snooze(ch);
                else if (sec_tick) begin
                    m_rc[ch]++;
                    if (m_rc[ch] >= RING_LEN) m_snooze(ch);
                end
            end else begin
                if (sec_tick) begin
                    m_cd[ch]--;
                    if (m_cd[ch] <= 0) begin
                        m_st[ch] = S_RING; m_rc[ch] = 0; m_cd[ch] = 0;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Compare process: outputs settle after the edge; inputs move at +3.
    always @(posedge clk) begin
        int e_idx;
        logic [3:0] e_arm, e_ring, e_snz;
        #2;
        if (m_valid) begin
            e_idx = -1; e_arm = '0; e_ring = '0; e_snz = '0;
            for (int ch = 0; ch < N; ch++) begin
                e_arm[ch]  = m_st[ch] != S_OFF;
                e_ring[ch] = m_st[ch] == S_RING;
                e_snz[ch]  = m_st[ch] == S_SNZ;
                if (e_idx < 0 && m_st[ch] == S_RING) e_idx = ch;
            end
            check("m_buzzer",  32'(alarm_buzzer), 32'(e_idx >= 0));
            check("m_ring_idx", 32'(ring_idx), 32'((e_idx < 0) ? 0 : e_idx));
            check("m_armed",   32'(armed),   32'(e_arm));
            check("m_ringing", 32'(ringing), 32'(e_ring));
            check("m_snoozed", 32'(snoozed), 32'(e_snz));
            check("m_sel_hr",  32'(sel_hr),  32'(m_hr[int'(sel)]));
            check("m_sel_min", 32'(sel_min), 32'(m_mn[int'(sel)]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
        add_hour = 0; add_minute = 0; set_alarm_btn = 0; clr_alarm_btn = 0;
        snooze_btn = 0; dismiss_btn = 0; sec_tick = 0;
    endtask

    task automatic ticks(input int n, input int h, input int m, input int s);
        for (int i = 0; i < n; i++) begin
            hr = 6'(h); min = 6'(m); sec = 6'(s); sec_tick = 1; cyc();
        end
    endtask

    task automatic edits(input int ch, input int nh, input int nm);
        sel = 2'(ch);
        for (int i = 0; i < nh; i++) begin add_hour = 1; cyc(); end
        for (int i = 0; i < nm; i++) begin add_minute = 1; cyc(); end
    endtask

    initial begin
        cyc(); cyc();
        reset = 1;
        check("rst_buzzer", 32'(alarm_buzzer), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_sel_hr", 32'(sel_hr), 0);

        // Reset while ringing silences the buzzer on the next edge.
        sel = 0; set_alarm_btn = 1; cyc();
        check("a_armed", 32'(armed), 32'h1);
        ticks(1, 0, 0, 0);
        check("a_buzzer_on", 32'(alarm_buzzer), 1);
        reset = 0; cyc();
        check("a_rst_buzzer", 32'(alarm_buzzer), 0);
        check("a_rst_masks", 32'({armed, ringing, snoozed}), 0);
        check("a_rst_time", 32'({sel_hr, sel_min}), 0);
        reset = 1;

        // Channel 1 at 07:30.
        edits(1, 7, 30);
        check("b_sel_hr", 32'(sel_hr), 7);
        check("b_sel_min", 32'(sel_min), 30);
        set_alarm_btn = 1; cyc();
        ticks(1, 7, 29, 58); ticks(1, 7, 29, 59);
        check("b_not_yet", 32'(ringing), 0);
        ticks(1, 7, 30, 0);
        check("b_ringing", 32'(ringing), 32'b0010);
        check("b_ring_idx", 32'(ring_idx), 1);
        check("b_buzzer", 32'(alarm_buzzer), 1);
        dismiss_btn = 1; cyc();
        check("b_dismissed", 32'({ringing, armed}), 32'b0000_0010);

        // Channels 0 and 2 at 06:00: lowest index owns the buzzer.
        edits(0, 6, 0); set_alarm_btn = 1; cyc();
        edits(2, 6, 0); set_alarm_btn = 1; cyc();
        ticks(1, 6, 0, 0);
        check("c_ringing", 32'(ringing), 32'b0101);
        check("c_ring_idx0", 32'(ring_idx), 0);
        dismiss_btn = 1; cyc();
        check("c_ring_idx2", 32'(ring_idx), 2);
        check("c_buzzer", 32'(alarm_buzzer), 1);
        check("c_armed", 32'(armed), 32'b0111);
        dismiss_btn = 1; cyc();
        sel = 2; clr_alarm_btn = 1; cyc();
        check("c_clr", 32'(armed), 32'b0011);

        // Snooze three times, the fourth acts as dismiss.
        ticks(1, 6, 0, 0);
        for (int k = 0; k < 3; k++) begin
            snooze_btn = 1; cyc();
            check("d_snoozed", 32'({alarm_buzzer, snoozed}), 32'b0_0001);
            ticks(SNOOZE_LEN - 1, 6, 0, 1);
            check("d_still_snz", 32'(snoozed), 32'b0001);
            ticks(1, 6, 0, 1);
            check("d_rerang", 32'(ringing), 32'b0001);
        end
        snooze_btn = 1; cyc();
        check("d_4th_dismiss", 32'({alarm_buzzer, ringing, snoozed, armed}), 32'b0_0000_0000_0011);

        // Ring timeout auto-snoozes; snooze+dismiss together dismiss.
        ticks(1, 6, 0, 0);
        ticks(RING_LEN - 1, 6, 0, 1);
        check("e_ring_59", 32'(ringing), 32'b0001);
        ticks(1, 6, 0, 1);
        check("e_auto_snz", 32'(snoozed), 32'b0001);
        ticks(SNOOZE_LEN, 6, 0, 1);
        check("e_rerang", 32'(ringing), 32'b0001);
        snooze_btn = 1; dismiss_btn = 1; cyc();
        check("e_both", 32'({snoozed, ringing, armed}), 32'b0000_0000_0011);

        // Edit wraparound and edits during ringing.
        edits(3, 23, 0);
        check("f_hr23", 32'(sel_hr), 23);
        edits(3, 1, 59);
        check("f_min59", 32'({sel_hr, sel_min}), 32'({6'd0, 6'd59}));
        edits(3, 0, 1);
        check("f_min_wrap", 32'({sel_hr, sel_min}), 0);
        ticks(1, 6, 0, 0);
        check("f_ring", 32'(alarm_buzzer), 1);
        edits(0, 0, 1);
        check("f_edit_ring", 32'({alarm_buzzer, ringing, armed}), 32'b0_0000_0010);
        check("f_edit_time", 32'({sel_hr, sel_min}), 32'({6'd6, 6'd1}));
        sel = 0; set_alarm_btn = 1; clr_alarm_btn = 1; cyc();
        check("f_clr_wins", 32'(armed), 32'b0010);
        add_hour = 1; set_alarm_btn = 1; cyc();
        check("f_edit_set", 32'({armed, sel_hr}), 32'({4'b0011, 6'd7}));

        // Randomized phase against the model.
        for (int i = 0; i < 5000; i++) begin
            int c, r;
            reset         = ($urandom_range(0, 799) != 0);
            sel           = 2'($urandom_range(0, 3));
            add_hour      = ($urandom_range(0, 39) == 0);
            add_minute    = ($urandom_range(0, 39) == 0);
            clr_alarm_btn = ($urandom_range(0, 39) == 0);
            set_alarm_btn = ($urandom_range(0, 5) == 0);
            snooze_btn    = ($urandom_range(0, 7) == 0);
            dismiss_btn   = ($urandom_range(0, 11) == 0);
            sec_tick      = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3);
            c = $urandom_range(0, N - 1);
            if (r == 0) begin
                hr = 6'(m_hr[c]); min = 6'(m_mn[c]); sec = 0;
            end else begin
                hr = 6'($urandom_range(0, 23)); min = 6'($urandom_range(0, 59));
                sec = (r == 1) ? 6'd0 : 6'($urandom_range(1, 59));
            end
            @(posedge clk);
            #3;
        end
        reset = 1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
